// File: rtl/dht11_pkg.sv
// dht11_pkg: shared types and constants for the DHT11 sensor emulator.
package dht11_pkg;

  typedef enum logic [3:0] {
    FIM,
    IDLE,
    HOST_LOW,
    ATRASO,
    RESP_LOW,
    RESP_HIGH,
    BIT_LOW,
    BIT_HIGH,
    END_LOW
  } estado_t;

  localparam int FRAME_BITS = 40;
  localparam int CNT_W      = 24;

  // Default protocol timing, in microseconds.
  localparam int T_START_MIN_US = 18000;
  localparam int T_WAIT_US      = 30;
  localparam int T_RESP_US      = 80;
  localparam int T_BIT_LOW_US   = 50;
  localparam int T_BIT0_US      = 26;
  localparam int T_BIT1_US      = 70;

  // Byte-wise sum of the four data bytes. The optional corruption flips
  // bit 0 so the host side can be shown a frame with a bad checksum.
  function automatic logic [7:0] checksum(input logic [15:0] umid,
                                          input logic [15:0] temp,
                                          input logic        corromper);
    logic [7:0] soma;
    soma = umid[15:8] + umid[7:0] + temp[15:8] + temp[7:0];
    return corromper ? (soma ^ 8'h01) : soma;
  endfunction

endpackage

// File: rtl/dht11_emulador_sincronizador.sv
// sincronizador: generic two-flop synchronizer with a selectable reset value.
module sincronizador #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; the reset value keeps an idle bus reading high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dht11_emulador.sv
// dht11_emulador: responder side of the DHT11 single-wire protocol. Detects
// the host start pulse on the open-drain line, answers with the presence
// sequence and shifts out a 40-bit humidity/temperature/checksum frame.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// FIM       | frame done or just reset; wait for the line to read high
// IDLE      | released; a low on the line (if enabled) starts a measurement
// HOST_LOW  | host holds the line low; count its length, decide on release
// ATRASO    | released; delay between host release and sensor response
// RESP_LOW  | sensor drives the presence low
// RESP_HIGH | released; presence high
// BIT_LOW   | sensor drives the low preamble of the current bit
// BIT_HIGH  | released; high length encodes the current bit (short 0, long 1)
// END_LOW   | sensor drives the closing low pulse after the last bit
module dht11_emulador
  import dht11_pkg::*;
#(
  parameter int CLK_HZ      = 50000000,
  parameter int T_START_MIN = T_START_MIN_US,
  parameter int T_WAIT      = T_WAIT_US,
  parameter int T_RESP      = T_RESP_US,
  parameter int T_BIT_LOW   = T_BIT_LOW_US,
  parameter int T_BIT0      = T_BIT0_US,
  parameter int T_BIT1      = T_BIT1_US
) (
  input  logic        clk,
  input  logic        reset,
  inout  wire         dado,
  input  logic [15:0] umidade,
  input  logic [15:0] temperatura,
  input  logic        habilitado,
  input  logic        corromper,
  output logic        ocupado,
  output logic        terminou
);

  localparam int TICKS_US = CLK_HZ / 1000000;

  // Terminal counts: each phase ends when the counter reaches T*TICKS_US-1.
  localparam logic [CNT_W-1:0] LIM_START   = CNT_W'(T_START_MIN * TICKS_US - 1);
  localparam logic [CNT_W-1:0] LIM_WAIT    = CNT_W'(T_WAIT * TICKS_US - 1);
  localparam logic [CNT_W-1:0] LIM_RESP    = CNT_W'(T_RESP * TICKS_US - 1);
  localparam logic [CNT_W-1:0] LIM_BIT_LOW = CNT_W'(T_BIT_LOW * TICKS_US - 1);
  localparam logic [CNT_W-1:0] LIM_BIT0    = CNT_W'(T_BIT0 * TICKS_US - 1);
  localparam logic [CNT_W-1:0] LIM_BIT1    = CNT_W'(T_BIT1 * TICKS_US - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [5:0]       ULTIMO_BIT  = 6'(FRAME_BITS - 1);

  estado_t                estado;
  logic [CNT_W-1:0]       ciclos;
  logic [FRAME_BITS-1:0]  frame;
  logic [5:0]             bitCnt;
  logic                   dirige;
  logic                   dadoS;
  logic [CNT_W-1:0]       limite;
  logic                   fimFase;

  sincronizador #(.RESET_VAL(1'b1)) uSinc (
    .clk   (clk),
    .reset (reset),
    .d     (dado),
    .q     (dadoS)
  );

  // Open-drain output: the sensor can only pull the line low.
  assign dado = dirige ? 1'b0 : 1'bz;

  // Length of the current timed phase; a bit's high time depends on the bit.
  always_comb begin
    limite = LIM_WAIT;
    case (estado)
      ATRASO:             limite = LIM_WAIT;
      RESP_LOW,
      RESP_HIGH:          limite = LIM_RESP;
      BIT_LOW,
      END_LOW:            limite = LIM_BIT_LOW;
      BIT_HIGH:           limite = frame[FRAME_BITS-1] ? LIM_BIT1 : LIM_BIT0;
      default:            limite = LIM_WAIT;
    endcase
    fimFase = (ciclos == limite);
  end

  // Protocol sequencer: phase timer, frame shifter and registered bus drive.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado   <= FIM;
      ciclos   <= '0;
      frame    <= '0;
      bitCnt   <= '0;
      dirige   <= 1'b0;
      ocupado  <= 1'b0;
      terminou <= 1'b0;
    end else begin
      terminou <= 1'b0;
      case (estado)
        FIM: begin
          ciclos <= '0;
          dirige <= 1'b0;
          if (dadoS) estado <= IDLE;
        end

        IDLE: begin
          ciclos <= '0;
          dirige <= 1'b0;
          if (!dadoS && habilitado) estado <= HOST_LOW;
        end

        HOST_LOW: begin
          // ciclos+1 is the number of low samples seen, including the one
          // that caused the entry into this state.
          if (dadoS) begin
            ciclos <= '0;
            if (ciclos < LIM_START) begin
              estado <= IDLE;
            end else begin
              frame   <= {umidade, temperatura,
                          checksum(umidade, temperatura, corromper)};
              bitCnt  <= '0;
              ocupado <= 1'b1;
              estado  <= ATRASO;
            end
          end else if (ciclos != CNT_MAX) begin
            ciclos <= ciclos + 1'b1;
          end
        end

        ATRASO: begin
          if (fimFase) begin
            ciclos <= '0;
            dirige <= 1'b1;
            estado <= RESP_LOW;
          end else begin
            ciclos <= ciclos + 1'b1;
          end
        end

        RESP_LOW: begin
          if (fimFase) begin
            ciclos <= '0;
            dirige <= 1'b0;
            estado <= RESP_HIGH;
          end else begin
            ciclos <= ciclos + 1'b1;
          end
        end

        RESP_HIGH: begin
          if (fimFase) begin
            ciclos <= '0;
            dirige <= 1'b1;
            estado <= BIT_LOW;
          end else begin
            ciclos <= ciclos + 1'b1;
          end
        end

        BIT_LOW: begin
          if (fimFase) begin
            ciclos <= '0;
            dirige <= 1'b0;
            estado <= BIT_HIGH;
          end else begin
            ciclos <= ciclos + 1'b1;
          end
        end

        BIT_HIGH: begin
          if (fimFase) begin
            ciclos <= '0;
            dirige <= 1'b1;
            frame  <= {frame[FRAME_BITS-2:0], 1'b0};
            bitCnt <= bitCnt + 1'b1;
            estado <= (bitCnt == ULTIMO_BIT) ? END_LOW : BIT_LOW;
          end else begin
            ciclos <= ciclos + 1'b1;
          end
        end

        END_LOW: begin
          if (fimFase) begin
            ciclos   <= '0;
            dirige   <= 1'b0;
            ocupado  <= 1'b0;
            terminou <= 1'b1;
            estado   <= FIM;
          end else begin
            ciclos <= ciclos + 1'b1;
          end
        end

        default: begin
          ciclos  <= '0;
          dirige  <= 1'b0;
          ocupado <= 1'b0;
          estado  <= FIM;
        end
      endcase
    end
  end

endmodule
